// File: rtl/reg_15_if.sv
// Bus bundle for register R15: write path from the core input bus and the two read paths.
interface reg_15_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] BIN;
   logic             WR;
   logic             LDBUS;
   logic             LDALU;
   logic [WIDTH-1:0] BOUT;
   logic [WIDTH-1:0] ALU;

   // Control-unit / bus side
   modport master (
      output BIN, WR, LDBUS, LDALU,
      input  BOUT, ALU
   );

   // Register side
   modport slave (
      input  BIN, WR, LDBUS, LDALU,
      output BOUT, ALU
   );
endinterface

// File: rtl/reg_15.sv
// General-purpose register R15: one storage word, written on WR and read combinationally on BOUT/ALU.
// Define REG15_BUS_TRISTATE_EN to float BOUT when not selected; otherwise BOUT idles at zero.
module reg_15 #(
   parameter int               WIDTH       = 16,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input logic     clk,
   input logic     RST,
   reg_15_if.slave bus
);

   logic [WIDTH-1:0] q;

   // BIN is only looked at under WR, so undriven bus bits cannot leak into q.
   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         q <= RESET_VALUE;
      end else if (bus.WR) begin
         q <= bus.BIN;
      end
   end

   assign bus.ALU = bus.LDALU ? q : '0;

`ifdef REG15_BUS_TRISTATE_EN
   assign bus.BOUT = bus.LDBUS ? q : 'z;
`else
   assign bus.BOUT = bus.LDBUS ? q : '0;
`endif

endmodule

// File: tb/tb_reg_15.sv
// Directed bench for reg_15: write-log model checked every cycle plus hand-computed spot checks.
module tb_reg_15;
   localparam int W = 16;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   bit   run = 1'b0;
   logic [W-1:0] idle;
   logic [W-1:0] wr_log[$];

   reg_15_if #(.WIDTH(W)) bus ();

   reg_15 #(.WIDTH(W)) dut (
      .clk (clk),
      .RST (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Model: Q is the most recent write accepted since the last reset, else the reset value.
   function automatic logic [W-1:0] model_q();
      return (wr_log.size() == 0) ? '0 : wr_log[$];
   endfunction

   always @(negedge rst) wr_log.delete();

   always @(posedge clk) begin
      if (rst === 1'b1 && bus.WR === 1'b1) wr_log.push_back(bus.BIN);
      else if (rst !== 1'b1) wr_log.delete();
   end

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare, well after the edge and before the next input change.
   always @(posedge clk) begin
      #2;
      if (run) begin
         check("bout_cyc", bus.BOUT, bus.LDBUS ? model_q() : idle);
         check("alu_cyc", bus.ALU, bus.LDALU ? model_q() : '0);
      end
   end

   task automatic step(input logic wr, input logic [W-1:0] bin, input logic ldbus, input logic ldalu);
      @(negedge clk);
      bus.WR    = wr;
      bus.BIN   = bin;
      bus.LDBUS = ldbus;
      bus.LDALU = ldalu;
   endtask

   initial begin
`ifdef REG15_BUS_TRISTATE_EN
      idle = 'z;
`else
      idle = '0;
`endif
      rst = 1'b0;
      bus.WR = 1'b0;
      bus.BIN = 'x;
      bus.LDBUS = 1'b0;
      bus.LDALU = 1'b0;
      #1;
      check("rst_bout_idle", bus.BOUT, idle);
      check("rst_alu_idle", bus.ALU, 16'h0000);

      // Strobes are ignored under reset; enabled outputs show the reset value.
      step(1'b1, 16'h1234, 1'b1, 1'b1);
      @(posedge clk); #1;
      check("rst_wr_ignored_bout", bus.BOUT, 16'h0000);
      check("rst_wr_ignored_alu", bus.ALU, 16'h0000);

      run = 1'b1;
      step(1'b0, 'x, 1'b0, 1'b0);
      rst = 1'b1;

      // Write 32, read on BOUT
      step(1'b1, 16'd32, 1'b0, 1'b0);
      step(1'b0, 'x, 1'b1, 1'b0);
      #1;
      check("wr32_bout", bus.BOUT, 16'd32);
      check("wr32_alu", bus.ALU, 16'h0000);

      // Overwrite with 64, read on ALU while BIN carries a different value
      step(1'b1, 16'd64, 1'b0, 1'b0);
      step(1'b0, 16'd32, 1'b0, 1'b1);
      #1;
      check("wr64_alu", bus.ALU, 16'd64);
      check("wr64_bout_idle", bus.BOUT, idle);
      @(posedge clk); #3;
      check("wr64_hold", bus.ALU, 16'd64);

      // Read-before-write in one cycle
      step(1'b1, 16'd5, 1'b1, 1'b0);
      #1;
      check("rbw_before", bus.BOUT, 16'd64);
      @(posedge clk); #1;
      check("rbw_after", bus.BOUT, 16'd5);

      // Asynchronous reset between edges with both reads enabled
      step(1'b0, 'x, 1'b1, 1'b1);
      #1;
      check("both_bout", bus.BOUT, 16'd5);
      check("both_alu", bus.ALU, 16'd5);
      @(posedge clk); #3;
      rst = 1'b0;
      #1;
      check("async_rst_bout", bus.BOUT, 16'h0000);
      check("async_rst_alu", bus.ALU, 16'h0000);

      // Reset release and write in the same cycle
      step(1'b1, 16'hA5A5, 1'b1, 1'b0);
      rst = 1'b1;
      #1;
      check("rel_before", bus.BOUT, 16'h0000);
      @(posedge clk); #1;
      check("rel_write", bus.BOUT, 16'hA5A5);

      // Idle bus with WR toggling: writes at i = 0, 2, 4
      for (int i = 0; i < 6; i++) begin
         step((i % 2) == 0, 16'h1000 + 16'(i), 1'b0, 1'b0);
         #1;
         check("idle_bout", bus.BOUT, idle);
      end
      step(1'b0, 'x, 1'b1, 1'b1);
      #1;
      check("idle_last_bout", bus.BOUT, 16'h1004);
      check("idle_last_alu", bus.ALU, 16'h1004);

      @(posedge clk); #3;
      run = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end
endmodule
